// File: rtl/alu_stim_gen.sv
// alu_stim_gen: weighted-random ALU transaction generator driven by a 64-bit
// Galois LFSR, with corner-only and fixed-op modes and a valid/ready output.
module alu_stim_gen #(
    parameter int          DATA_W  = 32,
    parameter int          COUNT_W = 16,
    parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [2:0]         fixed_op,
    input  logic [COUNT_W-1:0] txn_target,
    input  logic               seed_load,
    input  logic [63:0]        seed,
    input  logic               txn_ready,
    output logic               txn_valid,
    output logic [2:0]         txn_op,
    output logic               txn_rst,
    output logic [DATA_W-1:0]  txn_a,
    output logic [DATA_W-1:0]  txn_b,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] issued
);
    localparam logic [63:0] SEED_INIT = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [63:0] TAPS      = 64'hD800_0000_0000_0000;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic [1:0] MODE_CORNER = 2'b01;
    localparam logic [1:0] MODE_FIXED  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        GEN_OP,
        GEN_A,
        GEN_B,
        OFFER,
        DONE
    } state_t;

    state_t             state;
    logic [63:0]        lfsr;
    logic [63:0]        lfsr_next;
    logic [1:0]         mode_q;
    logic [2:0]         fixed_q;
    logic [COUNT_W-1:0] target_q;
    logic [COUNT_W-1:0] issued_inc;
    logic [3:0]         nib;
    logic [3:0]         sel;
    logic [DATA_W-1:0]  rnd;
    logic [DATA_W-1:0]  msb;
    logic [DATA_W-1:0]  operand;
    logic [2:0]         gen_op;
    logic               gen_rst;

    always_comb begin
        lfsr_next  = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? TAPS : 64'd0);
        nib        = lfsr_next[63:60];
        rnd        = lfsr_next[DATA_W-1:0];
        issued_inc = issued + COUNT_W'(1);
        // Corner mode folds the selector onto the eight fixed values only.
        sel = (mode_q == MODE_CORNER) ? {1'b0, nib[2:0]} : nib;
        msb = '0;
        msb[DATA_W-1] = 1'b1;
        case (sel)
            4'd0:    operand = '0;
            4'd1:    operand = DATA_W'(1);
            4'd2:    operand = msb - DATA_W'(1);
            4'd3:    operand = ~DATA_W'(1);
            4'd4:    operand = msb + DATA_W'(1);
            4'd5:    operand = msb - DATA_W'(2);
            4'd6:    operand = msb;
            4'd7:    operand = '1;
            default: operand = rnd;
        endcase
        gen_op  = OP_AND;
        gen_rst = 1'b0;
        if (mode_q == MODE_FIXED) begin
            gen_op = fixed_q;
        end else if (nib == 4'hF) begin
            gen_op  = OP_ADD;
            gen_rst = 1'b1;
        end else begin
            case (nib[1:0])
                2'd0:    gen_op = OP_AND;
                2'd1:    gen_op = OP_OR;
                2'd2:    gen_op = OP_ADD;
                default: gen_op = OP_SUB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED_INIT;
            mode_q    <= 2'b00;
            fixed_q   <= 3'b000;
            target_q  <= '0;
            txn_valid <= 1'b0;
            txn_op    <= 3'b000;
            txn_rst   <= 1'b0;
            txn_a     <= '0;
            txn_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            issued    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed == 64'd0) ? 64'd1 : seed;
                    end
                    if (start) begin
                        mode_q   <= mode;
                        fixed_q  <= fixed_op;
                        target_q <= txn_target;
                        issued   <= '0;
                        done     <= 1'b0;
                        if (txn_target != '0) begin
                            state <= GEN_OP;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                GEN_OP: begin
                    lfsr    <= lfsr_next;
                    txn_op  <= gen_op;
                    txn_rst <= gen_rst;
                    state   <= GEN_A;
                end
                GEN_A: begin
                    lfsr  <= lfsr_next;
                    txn_a <= operand;
                    state <= GEN_B;
                end
                GEN_B: begin
                    lfsr      <= lfsr_next;
                    txn_b     <= operand;
                    txn_valid <= 1'b1;
                    state     <= OFFER;
                end
                OFFER: begin
                    if (txn_ready) begin
                        txn_valid <= 1'b0;
                        issued    <= issued_inc;
                        if (issued_inc == target_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GEN_OP;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stim_gen.sv
// tb_alu_stim_gen: randomized scoreboard bench for alu_stim_gen against a
// transaction-level reference model of the LFSR-driven generator.
`timescale 1ns/1ps
module tb_alu_stim_gen;
    localparam int          W          = 32;
    localparam int          CW         = 16;
    localparam logic [63:0] RESET_SEED = 64'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [2:0]    fixed_op = 3'b000;
    logic [CW-1:0] txn_target = '0;
    logic          seed_load = 1'b0;
    logic [63:0]   seed = 64'd0;
    logic          txn_ready = 1'b0;
    logic          txn_valid;
    logic [2:0]    txn_op;
    logic          txn_rst;
    logic [W-1:0]  txn_a;
    logic [W-1:0]  txn_b;
    logic          busy;
    logic          done;
    logic [CW-1:0] issued;

    typedef struct packed {
        logic [2:0]   op;
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cap_q[$];
    txn_t        seq_a[$];
    txn_t        seq_b[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] model_l = RESET_SEED;
    bit          rdy_rand = 0;
    bit          corner_chk = 0;
    bit          capture = 0;
    bit          count_ops = 0;
    int          op_cnt[5] = '{0, 0, 0, 0, 0};
    int          cyc;
    logic [63:0] rs;
    logic [W-1:0] corner_set[8] = '{32'h0000_0000, 32'h0000_0001,
                                    32'h7FFF_FFFF, 32'hFFFF_FFFE,
                                    32'h8000_0001, 32'h7FFF_FFFE,
                                    32'h8000_0000, 32'hFFFF_FFFF};

    always #5 clk = ~clk;

    alu_stim_gen #(.DATA_W(W), .COUNT_W(CW), .SEED(RESET_SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .fixed_op(fixed_op), .txn_target(txn_target),
        .seed_load(seed_load), .seed(seed), .txn_ready(txn_ready),
        .txn_valid(txn_valid), .txn_op(txn_op), .txn_rst(txn_rst),
        .txn_a(txn_a), .txn_b(txn_b), .busy(busy), .done(done),
        .issued(issued)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] adv(input logic [63:0] l);
        logic [63:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 64'hD800_0000_0000_0000;
        return n;
    endfunction

    function automatic logic [W-1:0] pick(input logic [63:0] l, input logic [1:0] m);
        longint unsigned half;
        longint unsigned tbl[8];
        int s;
        half = 64'd1 << (W - 1);
        tbl = '{0, 1, half - 1, 2 * half - 2, half + 1, half - 2, half, 2 * half - 1};
        s = int'(l[63:60]);
        if (m == 2'b01) s = s % 8;
        if (s >= 8) return l[W-1:0];
        return W'(tbl[s]);
    endfunction

    task automatic model_txn(input logic [1:0] m, input logic [2:0] fo, output txn_t t);
        int n;
        model_l = adv(model_l);
        n = int'(model_l[63:60]);
        t.rst = 1'b0;
        if (m == 2'b10) t.op = fo;
        else if (n == 15) begin
            t.op  = 3'b100;
            t.rst = 1'b1;
        end else begin
            case (n % 4)
                0: t.op = 3'b000;
                1: t.op = 3'b001;
                2: t.op = 3'b100;
                default: t.op = 3'b101;
            endcase
        end
        model_l = adv(model_l);
        t.a = pick(model_l, m);
        model_l = adv(model_l);
        t.b = pick(model_l, m);
    endtask

    function automatic bit is_corner(input logic [W-1:0] v);
        foreach (corner_set[i]) if (corner_set[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: pops the scoreboard on each handshake, checks hold stability.
    initial begin
        txn_t cur;
        txn_t prev;
        txn_t e;
        bit   held;
        held = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !txn_valid) begin
                held = 0;
            end else begin
                cur.op = txn_op;
                cur.rst = txn_rst;
                cur.a = txn_a;
                cur.b = txn_b;
                if (held) check("hold_stable", cur, prev);
                if (txn_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL txn_unexpected: got %0h, required none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn", cur, e);
                    end
                    if (capture) cap_q.push_back(cur);
                    if (corner_chk) begin
                        check("corner_a", is_corner(cur.a), 1);
                        check("corner_b", is_corner(cur.b), 1);
                    end
                    if (count_ops) begin
                        if (cur.rst) op_cnt[4]++;
                        else case (cur.op)
                            3'b000: op_cnt[0]++;
                            3'b001: op_cnt[1]++;
                            3'b100: op_cnt[2]++;
                            default: op_cnt[3]++;
                        endcase
                    end
                    held = 0;
                end else begin
                    held = 1;
                    prev = cur;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) txn_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic run(input logic [1:0] m, input logic [2:0] fo, input int tgt,
                       input bit ld, input logic [63:0] sd, output int c);
        txn_t t;
        if (ld) model_l = (sd == 64'd0) ? 64'd1 : sd;
        for (int k = 0; k < tgt; k++) begin
            model_txn(m, fo, t);
            exp_q.push_back(t);
        end
        mode = m;
        fixed_op = fo;
        txn_target = CW'(tgt);
        seed = sd;
        seed_load = ld;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed_load = 1'b0;
        check("busy_after_start", busy, tgt > 0);
        c = 0;
        while (!done && c < tgt * 40 + 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("run_done", done, 1);
        check("run_issued", issued, tgt);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic compare_seq(input string name);
        check({name, "_len"}, seq_b.size(), seq_a.size());
        for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++)
            check(name, seq_b[i], seq_a[i]);
    endtask

    initial begin
        int c;
        logic [CW-1:0] iss0;
        #12;
        check("rst_valid", txn_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_issued", issued, 0);
        check("rst_payload", {txn_op, txn_rst, txn_a, txn_b}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(2'b00, 3'b000, 0, 0, 64'd0, cyc);
        check("zero_done_latency", cyc, 1);

        txn_ready = 1'b0;
        fork
            run(2'b00, 3'b000, 3, 0, 64'd0, cyc);
            begin
                c = 0;
                while (!txn_valid && c < 20) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                check("bp_valid_up", txn_valid, 1);
                iss0 = issued;
                repeat (10) @(posedge clk);
                #1;
                check("bp_valid_held", txn_valid, 1);
                check("bp_issued", issued, iss0);
                txn_ready = 1'b1;
            end
        join

        txn_ready = 1'b0;
        mode = 2'b00;
        txn_target = CW'(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (!txn_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("offer_reached", txn_valid, 1);
        check("offer_first_latency", c, 3);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", txn_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_issued", issued, 0);
        check("arst_payload", {txn_op, txn_rst, txn_a, txn_b}, 0);
        exp_q.delete();
        model_l = RESET_SEED;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        txn_ready = 1'b1;

        capture = 1;
        run(2'b00, 3'b000, 20, 0, 64'd0, cyc);
        capture = 0;
        seq_a = cap_q;
        cap_q.delete();

        corner_chk = 1;
        run(2'b01, 3'b000, 50, 0, 64'd0, cyc);
        corner_chk = 0;
        check("corner_run_cycles", cyc, 201);

        rdy_rand = 1;
        run(2'b10, 3'b101, 200, 0, 64'd0, cyc);
        run(2'b11, 3'b000, 30, 0, 64'd0, cyc);
        rdy_rand = 0;
        #0;
        txn_ready = 1'b1;

        count_ops = 1;
        run(2'b00, 3'b000, 2000, 0, 64'd0, cyc);
        count_ops = 0;
        check("ratio_and", op_cnt[0] > 325 && op_cnt[0] < 675, 1);
        check("ratio_or", op_cnt[1] > 325 && op_cnt[1] < 675, 1);
        check("ratio_add", op_cnt[2] > 325 && op_cnt[2] < 675, 1);
        check("ratio_sub", op_cnt[3] > 240 && op_cnt[3] < 510, 1);
        check("ratio_rst", op_cnt[4] > 60 && op_cnt[4] < 190, 1);

        capture = 1;
        run(2'b00, 3'b000, 20, 1, 64'd0, cyc);
        seq_b = cap_q;
        cap_q.delete();
        compare_seq("seed0_vs_reset");

        rs = {$urandom, $urandom} | 64'h1;
        run(2'b00, 3'b000, 20, 1, rs, cyc);
        seq_a = cap_q;
        cap_q.delete();
        run(2'b00, 3'b000, 20, 1, rs, cyc);
        seq_b = cap_q;
        cap_q.delete();
        capture = 0;
        compare_seq("same_seed");

        fork
            run(2'b00, 3'b000, 20, 0, 64'd0, cyc);
            begin
                repeat (6) @(posedge clk);
                #2;
                seed = {$urandom, $urandom};
                seed_load = 1'b1;
                @(posedge clk);
                #2;
                seed_load = 1'b0;
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
